multiplier: RTL and testbench
=============================

Name: multiplier

Overview:
- Iterative unsigned shift-add multiplier: one multiplier bit per clock.
- Takes two WIDTH-bit operands and returns a 2*WIDTH-bit product.
- Flags whether the product exceeds WIDTH bits.
- Sits as a multi-cycle arithmetic unit behind a simple start/valid handshake; area-cheap alternative to a combinational multiplier.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous active-low reset.
- en  in  1  start request; sampled only while IDLE.
- op1  in  WIDTH  multiplicand, captured at start.
- op2  in  WIDTH  multiplier, captured at start.
- res  out  2*WIDTH  product of the last completed operation.
- val  out  1  one-cycle pulse: res/overflow just updated.
- overflow  out  1  product does not fit in WIDTH bits (res[2W-1:W] != 0).

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, res=0, val=0, overflow=0, and clears internal accumulator, operand registers and counter.
- Reset mid-operation aborts the operation; no val is produced.
- States:
  - IDLE: waiting.
  - BUSY: iterating.
- IDLE -> BUSY when en=1 at a rising edge (edge k).
  - At edge k: latch op1 into a 2*WIDTH multiplicand shift register (zero-extended).
  - Latch op2 into the multiplier shift register.
  - Clear the accumulator and the counter.
- BUSY, each edge:
  - If multiplier LSB=1, accumulator += multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1; counter +1.
- Completion at edge k+WIDTH, i.e. after exactly WIDTH busy cycles:
  - res <= final accumulator; overflow <= |final[2W-1:W]; val <= 1; state <= IDLE.
- val is high for exactly the one cycle following the completion edge, then returns to 0.
- res and overflow hold until the next completion or reset.
- During BUSY, res/overflow keep the previous result; the running sum is never exposed.
- en is ignored in BUSY; op1/op2 may change freely after edge k.
- Back-to-back: en=1 in the val cycle is accepted, since the state is already IDLE.
  - The new op starts at edge k+WIDTH+1; val drops at that edge.
- Arithmetic:
  - Unsigned only.
  - Accumulator is 2*WIDTH bits and cannot overflow: max product (2^W-1)^2 < 2^(2W).
- Steady throughput without early termination: one result per WIDTH+1 cycles.

Optional Feature:
- Macro MULTIPLIER_EARLY_TERM_EN.
- Defined:
  - BUSY ends at the first iteration after which the shifted multiplier register is zero.
  - Latency = max(1, index of op2's highest set bit + 1) cycles.
  - Examples: op2=15 -> done at edge k+4; op2=0 -> done at edge k+1.
- Undefined: fixed WIDTH-cycle latency.
- Results and handshake are identical in both builds; only latency differs.

Decomposition:
- Package multiplier_pkg:
  - Default width constant MUL_WIDTH=32.
  - State enum mul_state_t {IDLE, BUSY}.
  - Counter width constant $clog2(WIDTH+1).
- One sub-module is natural: multiplier_datapath.
  - Holds the shift registers and accumulator.
  - Inputs: load and step.
  - Outputs: product and multiplier-is-zero.
- The top level keeps the FSM, counter and output registers.

Test Plan:
- op1=27, op2=15, en pulse -> after 32 cycles (4 with early-term) val=1 for one cycle, res=405, overflow=0.
- op1=0xFFFFFFFF, op2=0xFFFFFFFF -> res=0xFFFFFFFE00000001, overflow=1, val after 32 cycles.
- op1=0x10000, op2=0x10000 -> res=0x100000000, overflow=1; op1=0xFFFF, op2=0xFFFF -> res=0xFFFE0001, overflow=0.
- op1=1234, op2=0 -> res=0, overflow=0; latency 32 (1 with early-term); previous res held until completion.
- en held high continuously with changing operands -> results every 33 cycles, each matching operands sampled at its start edge; en toggled during BUSY ignored.
- Assert rst_n low at cycle 10 of an operation -> res=0, val=0, overflow=0 immediately; no val pulse afterward; a new op after release completes correctly.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared constants and types for the iterative shift-add multiplier.
package multiplier_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/multiplier_datapath.sv
// Shift registers and accumulator for the shift-add multiplier.
// The multiplier-zero output exists only when MULTIPLIER_EARLY_TERM_EN is defined.
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic [WIDTH-1:0]     i_op1,
  input  logic [WIDTH-1:0]     i_op2,
  output logic [2*WIDTH-1:0]   o_product
`ifdef MULTIPLIER_EARLY_TERM_EN
  ,
  output logic                 o_mplr_zero
`endif
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;

  // Sum including the current step, so completion can capture it on the same edge.
  assign w_acc_next = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign o_product  = w_acc_next;

`ifdef MULTIPLIER_EARLY_TERM_EN
  assign o_mplr_zero = ((r_mplr >> 1) == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
    end else if (i_load) begin
      r_mcand <= {{WIDTH{1'b0}}, i_op1};
      r_mplr  <= i_op2;
      r_acc   <= '0;
    end else if (i_step) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
    end
  end

endmodule

// File: rtl/multiplier.sv
// Iterative unsigned multiplier: one multiplier bit per clock, start/valid handshake.
// Define MULTIPLIER_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module multiplier
  import multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     op1,
  input  logic [WIDTH-1:0]     op2,
  output logic [2*WIDTH-1:0]   res,
  output logic                 val,
  output logic                 overflow
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mul_state_t         r_state;
  mul_state_t         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_load;
  logic               w_step;
  logic               w_done;
  logic               w_last;
  logic [2*WIDTH-1:0] w_product;
  logic [2*WIDTH-1:0] r_res;
  logic               r_val;
  logic               r_ovf;

`ifdef MULTIPLIER_EARLY_TERM_EN
  logic w_mplr_zero;
  // The count bound is redundant here but keeps the counter meaningful in both builds.
  assign w_last = w_mplr_zero || (r_cnt == CNT_LAST);
`else
  assign w_last = (r_cnt == CNT_LAST);
`endif

  multiplier_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_op1       (op1),
    .i_op2       (op2),
    .o_product   (w_product)
`ifdef MULTIPLIER_EARLY_TERM_EN
    ,
    .o_mplr_zero (w_mplr_zero)
`endif
  );

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_load       = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (w_last) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_cnt <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Result registers change only on completion; the running sum stays internal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_ovf <= 1'b0;
      r_val <= 1'b0;
    end else begin
      r_val <= w_done;
      if (w_done) begin
        r_res <= w_product;
        r_ovf <= |w_product[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign res      = r_res;
  assign val      = r_val;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the iterative multiplier; expected products are hand-computed constants.
module tb_multiplier;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] res;
  logic        val;
  logic        overflow;

  int          n_cmp;
  int          n_err;
  logic [63:0] last_res;
  logic        last_ovf;

  multiplier #(
    .WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .op1      (op1),
    .op2      (op2),
    .res      (res),
    .val      (val),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input logic [31:0] b);
`ifdef MULTIPLIER_EARLY_TERM_EN
    int m;
    m = 0;
    for (int i = 0; i < 32; i++) if (b[i]) m = i + 1;
    return (m == 0) ? 1 : m;
`else
    return 32;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One isolated operation: checks held outputs while busy, the val pulse, and its drop.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_res, input logic exp_ovf);
    int l;
    l = lat(b);
    @(negedge clk);
    en  = 1'b1;
    op1 = a;
    op2 = b;
    @(posedge clk);
    #1;
    en  = 1'b0;
    op1 = $urandom;
    op2 = $urandom;
    for (int j = 1; j <= l; j++) begin
      @(posedge clk);
      #1;
      if (j < l) begin
        chk({tag, "_busy_val"}, {63'd0, val}, 64'd0);
        chk({tag, "_busy_res"}, res, last_res);
        chk({tag, "_busy_ovf"}, {63'd0, overflow}, {63'd0, last_ovf});
        en = $urandom_range(0, 1);
      end else begin
        chk({tag, "_val"}, {63'd0, val}, 64'd1);
        chk({tag, "_res"}, res, exp_res);
        chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, exp_ovf});
        en = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_val_drop"}, {63'd0, val}, 64'd0);
    chk({tag, "_res_hold"}, res, exp_res);
    last_res = exp_res;
    last_ovf = exp_ovf;
  endtask

  logic [31:0] bb_a   [3];
  logic [31:0] bb_b   [3];
  logic [63:0] bb_res [3];
  logic        bb_ovf [3];
  int          seen;

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    last_res = 64'd0;
    last_ovf = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    op1      = 32'd0;
    op2      = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_res", res, 64'd0);
    chk("reset_val", {63'd0, val}, 64'd0);
    chk("reset_ovf", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_val", {63'd0, val}, 64'd0);

    run_op("m27x15", 32'd27, 32'd15, 64'd405, 1'b0);
    run_op("mmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
    run_op("m2p16", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
    run_op("mffff", 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 1'b0);
    run_op("mzero", 32'd1234, 32'd0, 64'd0, 1'b0);

    // Back-to-back: en high in each val cycle starts the next operation immediately.
    bb_a[0] = 32'd3;         bb_b[0] = 32'd5; bb_res[0] = 64'd15;                  bb_ovf[0] = 1'b0;
    bb_a[1] = 32'h8000_0000; bb_b[1] = 32'd2; bb_res[1] = 64'h0000_0001_0000_0000; bb_ovf[1] = 1'b1;
    bb_a[2] = 32'hFFFF_FFFF; bb_b[2] = 32'd1; bb_res[2] = 64'h0000_0000_FFFF_FFFF; bb_ovf[2] = 1'b0;
    @(negedge clk);
    en  = 1'b1;
    op1 = bb_a[0];
    op2 = bb_b[0];
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      int l;
      l   = lat(bb_b[n]);
      en  = $urandom_range(0, 1);
      op1 = $urandom;
      op2 = $urandom;
      for (int j = 1; j <= l; j++) begin
        @(posedge clk);
        #1;
        if (j < l) begin
          chk("b2b_busy_val", {63'd0, val}, 64'd0);
          chk("b2b_busy_res", res, last_res);
          en  = $urandom_range(0, 1);
          op1 = $urandom;
          op2 = $urandom;
        end else begin
          chk("b2b_val", {63'd0, val}, 64'd1);
          chk("b2b_res", res, bb_res[n]);
          chk("b2b_ovf", {63'd0, overflow}, {63'd0, bb_ovf[n]});
          last_res = bb_res[n];
          last_ovf = bb_ovf[n];
          if (n < 2) begin
            en  = 1'b1;
            op1 = bb_a[n+1];
            op2 = bb_b[n+1];
          end else begin
            en = 1'b0;
          end
        end
      end
      @(posedge clk);
      #1;
      chk("b2b_val_drop", {63'd0, val}, 64'd0);
    end

    // Reset in the middle of an operation aborts it with no val pulse.
    @(negedge clk);
    en  = 1'b1;
    op1 = 32'd100;
    op2 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst_res", res, last_res);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res", res, 64'd0);
    chk("mid_rst_val", {63'd0, val}, 64'd0);
    chk("mid_rst_ovf", {63'd0, overflow}, 64'd0);
    last_res = 64'd0;
    last_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      if (val) seen++;
    end
    chk("post_rst_no_val", 64'(seen), 64'd0);
    chk("post_rst_res", res, 64'd0);

    run_op("after_rst", 32'd7, 32'd6, 64'd42, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
